// File: rtl/fetch_stage.sv
// fetch_stage: PC ownership, IF/ID capture, stall/redirect handling and end-of-program halt
module fetch_stage #(
    parameter int          MEM_DEPTH = 58,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_next,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state;
    logic [31:0] pc;
    logic        in_range;
    assign imem_pc  = pc;
    assign halted   = state == HALT;
    assign in_range = pc < 32'(MEM_DEPTH);
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            state         <= RUN;
            if_id_instr   <= '0;
            if_id_pc      <= '0;
            if_id_pc_next <= '0;
            if_id_valid   <= 1'b0;
            fetch_count   <= '0;
        end else if (redirect_valid) begin
            pc            <= redirect_target;
            state         <= RUN;
            if_id_instr   <= '0;
            if_id_pc      <= '0;
            if_id_pc_next <= '0;
            if_id_valid   <= 1'b0;
        end else if (!stall) begin
            // Running past the end parks the PC; only a redirect can revive it.
            if (state == RUN && in_range) begin
                pc            <= pc + 32'd1;
                if_id_instr   <= imem_instr;
                if_id_pc      <= pc;
                if_id_pc_next <= pc + 32'd1;
                if_id_valid   <= 1'b1;
                fetch_count   <= fetch_count + 32'd1;
            end else begin
                state         <= HALT;
                if_id_instr   <= '0;
                if_id_pc      <= '0;
                if_id_pc_next <= '0;
                if_id_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit MIPS pipeline, sitting directly upstream of the instruction memory. It owns the program counter, drives the word address into `instr_mem`, and captures the returned instruction into the IF/ID pipeline register. It also handles stalls from the hazard unit, branch/jump redirects resolved later in the pipeline, and end-of-program halt detection.

## Interface
- `MEM_DEPTH`, 58: number of valid instruction words. Addresses `>= MEM_DEPTH` are out of range.
- `RESET_PC`, 0: PC value after reset. Must be `< MEM_DEPTH`.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC, IF/ID and state for this cycle.
- `redirect_valid` in 1: branch or jump taken; load `redirect_target`.
- `redirect_target` in 32: new PC, as a word index.
- `imem_pc` out 32: address to `instr_mem`; equals the PC register.
- `imem_instr` in 32: combinational instruction from `instr_mem` for `imem_pc`.
- `if_id_instr` out 32: registered instruction.
- `if_id_pc` out 32: PC of `if_id_instr`.
- `if_id_pc_next` out 32: `if_id_pc + 1`.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: high while the FSM is in HALT.
- `fetch_count` out 32: number of instructions loaded into IF/ID since reset.

## Operation
- The PC is a word index; one increment is one instruction. All PC arithmetic is mod 2^32.
- FSM states:
  - RUN: fetching.
  - HALT: PC ran past the end of memory; no fetching.
- Edge priority: `reset` > `redirect_valid` > `stall` > normal.
- `reset`:
  - PC := `RESET_PC`; state := RUN.
  - `if_id_instr`, `if_id_pc`, `if_id_pc_next`, `fetch_count` := 0; `if_id_valid` := 0.
  - This applies regardless of `stall` or `redirect_valid`.
- Redirect, in any state:
  - PC := `redirect_target`; state := RUN.
  - IF/ID is squashed: instr/pc/pc_next := 0, valid := 0.
  - `fetch_count` unchanged.
  - `stall` is ignored in that cycle.
- Stall (no redirect): PC, IF/ID, state and `fetch_count` all hold their values.
- RUN, normal, PC `< MEM_DEPTH`:
  - IF/ID := {`imem_instr`, PC, PC+1, valid=1}.
  - PC := PC+1.
  - `fetch_count` += 1, wrapping at 2^32.
- RUN, normal, PC `>= MEM_DEPTH`:
  - state := HALT; IF/ID squashed (all 0, valid 0).
  - PC holds; `fetch_count` unchanged.
- HALT, normal: PC holds, IF/ID stays squashed. Only a redirect or reset leaves HALT, because older branches still in flight may jump back into range.
- A redirect to an out-of-range target is legal. Behaviour: one RUN cycle with no fetch, then HALT.
- An all-zero `imem_instr` (NOP) is captured as a valid instruction.

## Timing
- `imem_pc` is combinational from the PC register; `instr_mem` returns the instruction in the same cycle.
- Fetch latency is 1 cycle: an instruction at `imem_pc` in cycle N appears on `if_id_*` in cycle N+1.
- Redirect penalty is 1 bubble. With redirect in cycle N:
  - cycle N+1: `if_id_valid`=0 and `imem_pc`=target.
  - cycle N+2: `if_id_pc`=target.
- `halted` is decoded from the state register. It rises the cycle after the edge that enters HALT and falls the cycle after a redirect edge.
- Reset values of all outputs: `imem_pc`=`RESET_PC`; every other output is 0.

## Test plan
- Free run: reset, then 4 cycles with no stall or redirect.
  - `imem_pc` = 0,1,2,3.
  - `if_id_pc` = 0,0,1,2, with `if_id_valid` = 0,1,1,1.
  - `if_id_pc_next` = `if_id_pc`+1.
  - `if_id_instr` matches the memory word at that address.
- Stall: at `imem_pc`=4, assert `stall` for 2 cycles.
  - `imem_pc` stays 4; `if_id_pc` stays 3; `fetch_count` stays 4.
  - After release: `if_id_pc`=4, `imem_pc`=5.
- Redirect: at `imem_pc`=6, drive `redirect_valid`=1, target=2, with `stall`=1 in the same cycle.
  - Next cycle: `imem_pc`=2, `if_id_valid`=0, `fetch_count` unchanged.
  - Cycle after: `if_id_pc`=2, valid=1.
- End of program: free run from 0 with `MEM_DEPTH`=58.
  - Last valid `if_id_pc`=57; `fetch_count`=58.
  - `halted`=1 one cycle after `imem_pc` reaches 58.
  - `imem_pc` then stays 58 and `if_id_valid` stays 0 for 5+ cycles.
- Resume from HALT: redirect to 10 while halted.
  - `halted` drops next cycle; `imem_pc`=10.
  - `if_id_pc`=10, valid=1 the following cycle.
  - Redirect to 100: `halted` returns after one cycle with no fetch and no `fetch_count` change.
- Reset mid-operation: at `imem_pc`=20, assert `reset`, `stall` and `redirect_valid` together.
  - All outputs at reset values next cycle; `imem_pc`=`RESET_PC`.
  - Fetching restarts from 0 after `reset` deasserts.
